// File: rtl/aq_axi_sdma64_rdpush.sv
`default_nettype none
// ============================================================================
// Module   : aq_axi_sdma64_rdpush
// Purpose  : Takes AXI read data beats for one job of LEN beats and pushes
//            them into a downstream FIFO through a 2-entry skid buffer.
//            FIFO word is {RLAST, RDATA}.
// Options  : define AQ_AXI_SDMA64_RDPUSH_CHK_EN to enable the sticky RRESP
//            error flag (ERR); otherwise ERR is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module aq_axi_sdma64_rdpush #(
    parameter int BEAT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [BEAT_W-1:0] LEN,
    input  logic              S_RVALID,
    output logic              S_RREADY,
    input  logic [63:0]       S_RDATA,
    input  logic              S_RLAST,
    input  logic [1:0]        S_RRESP,
    output logic              FIFO_WREN,
    output logic [64:0]       FIFO_DI,
    input  logic              FIFO_FULL,
    input  logic              FIFO_AFULL,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [BEAT_W-1:0] BEATS
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          occ_q, occ_d;
    logic [64:0]         head_q, head_d;
    logic [64:0]         tail_q, tail_d;
    logic [BEAT_W-1:0]   rem_q, rem_d;
    logic [BEAT_W-1:0]   beats_q, beats_d;
    logic                done_q, done_d;
    logic                rready_q, rready_d;
    logic                job_start;

    logic                w_wren;
    logic                w_accept;
    logic [1:0]          w_occ_pop;
    logic [64:0]         w_beat;

    // Handshakes: pop the head whenever the FIFO can take it, accept a beat
    // whenever the registered ready meets a valid.
    always_comb begin
        w_wren    = (occ_q != 2'd0) && !FIFO_FULL;
        w_accept  = S_RVALID && rready_q;
        w_beat    = {S_RLAST, S_RDATA};
        w_occ_pop = occ_q - {1'b0, w_wren};
    end

    // Next-state computation for the skid buffer, counters and job FSM.
    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        rem_d     = rem_q;
        beats_d   = beats_q;
        done_d    = 1'b0;
        job_start = 1'b0;

        // Pop shifts the tail forward; a stale copy left in head is harmless
        // because occupancy says it is empty.
        if (w_wren) begin
            head_d  = tail_q;
            beats_d = beats_q + BEAT_W'(1);
        end
        // A new beat lands in the first free slot after the pop.
        if (w_accept) begin
            if (w_occ_pop == 2'd0) begin
                head_d = w_beat;
            end else begin
                tail_d = w_beat;
            end
            rem_d = rem_q - BEAT_W'(1);
        end
        occ_d = w_occ_pop + {1'b0, w_accept};

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (LEN != '0) begin
                        state_d   = ST_RUN;
                        rem_d     = LEN;
                        beats_d   = '0;
                        job_start = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (rem_d == '0) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (occ_d == 2'd0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Ready is only offered when the beat it admits is guaranteed a slot.
        rready_d = (state_d == ST_RUN) && (occ_d <= 2'd1) &&
                   (rem_d != '0) && !FIFO_AFULL;
    end

    // State and datapath registers, cleared asynchronously on RST.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            occ_q    <= 2'd0;
            head_q   <= '0;
            tail_q   <= '0;
            rem_q    <= '0;
            beats_q  <= '0;
            done_q   <= 1'b0;
            rready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            occ_q    <= occ_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            rem_q    <= rem_d;
            beats_q  <= beats_d;
            done_q   <= done_d;
            rready_q <= rready_d;
        end
    end

`ifdef AQ_AXI_SDMA64_RDPUSH_CHK_EN
    logic err_q;

    // Sticky response error: set by any accepted non-OKAY beat, cleared
    // when a new job starts.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (job_start) begin
            err_q <= 1'b0;
        end else if (w_accept && (S_RRESP != 2'b00)) begin
            err_q <= 1'b1;
        end
    end

    assign ERR = err_q;
`else
    logic w_unused_rresp;
    assign w_unused_rresp = ^{S_RRESP, job_start};
    assign ERR = 1'b0;
`endif

    assign S_RREADY  = rready_q;
    assign FIFO_WREN = w_wren;
    assign FIFO_DI   = head_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign DONE      = done_q;
    assign BEATS     = beats_q;

endmodule
`default_nettype wire

// File: tb/tb_aq_axi_sdma64_rdpush.sv
`default_nettype none
// ============================================================================
// Module   : tb_aq_axi_sdma64_rdpush
// Purpose  : Directed self-checking bench for aq_axi_sdma64_rdpush.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aq_axi_sdma64_rdpush;

    localparam int BEAT_W = 16;

    logic              clk;
    logic              RST;
    logic              START;
    logic [BEAT_W-1:0] LEN;
    logic              S_RVALID;
    logic              S_RREADY;
    logic [63:0]       S_RDATA;
    logic              S_RLAST;
    logic [1:0]        S_RRESP;
    logic              FIFO_WREN;
    logic [64:0]       FIFO_DI;
    logic              FIFO_FULL;
    logic              FIFO_AFULL;
    logic              BUSY;
    logic              DONE;
    logic              ERR;
    logic [BEAT_W-1:0] BEATS;

    int tests = 0;
    int fails = 0;

    // Source model
    logic        src_en;
    logic        src_clr;
    logic [63:0] src_base;
    int          src_idx;
    int          src_last;
    int          err_idx;

    // FIFO-side monitor
    logic [64:0] wr_q[$];
    int          full_viol = 0;

`ifdef AQ_AXI_SDMA64_RDPUSH_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    aq_axi_sdma64_rdpush #(.BEAT_W(BEAT_W)) dut (
        .CLK        (clk),
        .RST        (RST),
        .START      (START),
        .LEN        (LEN),
        .S_RVALID   (S_RVALID),
        .S_RREADY   (S_RREADY),
        .S_RDATA    (S_RDATA),
        .S_RLAST    (S_RLAST),
        .S_RRESP    (S_RRESP),
        .FIFO_WREN  (FIFO_WREN),
        .FIFO_DI    (FIFO_DI),
        .FIFO_FULL  (FIFO_FULL),
        .FIFO_AFULL (FIFO_AFULL),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR),
        .BEATS      (BEATS)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign S_RVALID = src_en;
    assign S_RDATA  = src_base + 64'(src_idx);
    assign S_RLAST  = (src_idx == src_last);
    assign S_RRESP  = (src_idx == err_idx) ? 2'b10 : 2'b00;

    always @(posedge clk) begin
        if (src_clr)
            src_idx <= 0;
        else if (S_RVALID && S_RREADY)
            src_idx <= src_idx + 1;
    end

    always @(posedge clk) begin
        if (FIFO_WREN) begin
            wr_q.push_back(FIFO_DI);
            if (FIFO_FULL) full_viol = full_viol + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_src(input logic [63:0] base, input int last, input int eidx);
        src_en   = 1'b0;
        src_clr  = 1'b1;
        src_base = base;
        src_last = last;
        err_idx  = eidx;
        tick();
        src_clr  = 1'b0;
        wr_q.delete();
    endtask

    task automatic start_job(input logic [BEAT_W-1:0] len);
        START = 1'b1;
        LEN   = len;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!DONE && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {64'd0, DONE}, 65'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; START = 1'b0; LEN = '0;
        src_en = 1'b0; src_clr = 1'b1; src_base = '0; src_last = -1; err_idx = -1;
        FIFO_FULL = 1'b0; FIFO_AFULL = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_rready", {64'd0, S_RREADY}, 65'd0);
        chk("rst_wren",   {64'd0, FIFO_WREN}, 65'd0);
        chk("rst_di",     FIFO_DI, 65'd0);
        chk("rst_busy",   {64'd0, BUSY}, 65'd0);
        chk("rst_done",   {64'd0, DONE}, 65'd0);
        chk("rst_err",    {64'd0, ERR}, 65'd0);
        chk("rst_beats",  65'(BEATS), 65'd0);
        RST = 1'b0;
        tick();
        chk("post_rst_busy", {64'd0, BUSY}, 65'd0);

        // A: LEN=4, continuous valid, free FIFO
        clear_src(64'hA000_0000_0000_0000, 3, -1);
        src_en = 1'b1;
        start_job(16'd4);
        chk("A_busy", {64'd0, BUSY}, 65'd1);
        chk("A_rready", {64'd0, S_RREADY}, 65'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("A_wren", {64'd0, FIFO_WREN}, 65'd1);
            chk("A_di", FIFO_DI, {(i == 3), 64'hA000_0000_0000_0000 + 64'(i)});
        end
        chk("A_busy_flush", {64'd0, BUSY}, 65'd1);
        tick();
        src_en = 1'b0;
        chk("A_wren_end", {64'd0, FIFO_WREN}, 65'd0);
        chk("A_done", {64'd0, DONE}, 65'd1);
        chk("A_beats", 65'(BEATS), 65'd4);
        chk("A_idle", {64'd0, BUSY}, 65'd0);
        tick();
        chk("A_done_pulse", {64'd0, DONE}, 65'd0);
        chk("A_wr_count", 65'(wr_q.size()), 65'd4);

        // B: LEN=8, AFULL for 5 cycles after beat 2
        clear_src(64'hB000_0000_0000_0000, 7, -1);
        src_en = 1'b1;
        start_job(16'd8);
        tick(); tick();
        FIFO_AFULL = 1'b1;
        tick();
        chk("B_rready_drop", {64'd0, S_RREADY}, 65'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("B_rready_hold", {64'd0, S_RREADY}, 65'd0);
        end
        FIFO_AFULL = 1'b0;
        wait_done("B_done", 40);
        src_en = 1'b0;
        chk("B_beats", 65'(BEATS), 65'd8);
        chk("B_wr_count", 65'(wr_q.size()), 65'd8);
        for (int i = 0; i < 8; i++)
            chk("B_order", wr_q[i], {(i == 7), 64'hB000_0000_0000_0000 + 64'(i)});

        // C: FULL with two entries held
        clear_src(64'hC000_0000_0000_0000, 1, -1);
        FIFO_FULL = 1'b1;
        src_en = 1'b1;
        start_job(16'd2);
        tick(); tick();
        chk("C_wren_full", {64'd0, FIFO_WREN}, 65'd0);
        chk("C_rready_full", {64'd0, S_RREADY}, 65'd0);
        tick();
        chk("C_wren_full2", {64'd0, FIFO_WREN}, 65'd0);
        FIFO_FULL = 1'b0;
        #1;
        chk("C_wren_0", {64'd0, FIFO_WREN}, 65'd1);
        chk("C_di_0", FIFO_DI, {1'b0, 64'hC000_0000_0000_0000});
        tick();
        chk("C_wren_1", {64'd0, FIFO_WREN}, 65'd1);
        chk("C_di_1", FIFO_DI, {1'b1, 64'hC000_0000_0000_0001});
        tick();
        src_en = 1'b0;
        chk("C_done", {64'd0, DONE}, 65'd1);
        chk("C_beats", 65'(BEATS), 65'd2);
        chk("C_wr_count", 65'(wr_q.size()), 65'd2);

        // D: LEN=0 and START during RUN
        clear_src(64'hD000_0000_0000_0000, 2, -1);
        start_job(16'd0);
        chk("D_len0_rready", {64'd0, S_RREADY}, 65'd0);
        chk("D_len0_busy", {64'd0, BUSY}, 65'd0);
        chk("D_len0_done", {64'd0, DONE}, 65'd1);
        tick();
        chk("D_len0_done_pulse", {64'd0, DONE}, 65'd0);
        start_job(16'd3);
        tick(); tick();
        start_job(16'd5);
        chk("D_run_busy", {64'd0, BUSY}, 65'd1);
        src_en = 1'b1;
        wait_done("D_done", 40);
        src_en = 1'b0;
        chk("D_beats", 65'(BEATS), 65'd3);
        chk("D_wr_count", 65'(wr_q.size()), 65'd3);

        // E: reset mid-job after 3 of 6 beats
        clear_src(64'hE000_0000_0000_0000, 5, -1);
        src_en = 1'b1;
        start_job(16'd6);
        tick(); tick(); tick();
        chk("E_pre_writes", 65'(wr_q.size()), 65'd2);
        RST = 1'b1;
        #1;
        chk("E_rst_rready", {64'd0, S_RREADY}, 65'd0);
        chk("E_rst_wren", {64'd0, FIFO_WREN}, 65'd0);
        chk("E_rst_di", FIFO_DI, 65'd0);
        chk("E_rst_busy", {64'd0, BUSY}, 65'd0);
        chk("E_rst_done", {64'd0, DONE}, 65'd0);
        chk("E_rst_err", {64'd0, ERR}, 65'd0);
        chk("E_rst_beats", 65'(BEATS), 65'd0);
        tick(); tick();
        RST = 1'b0;
        tick();
        chk("E_post_busy", {64'd0, BUSY}, 65'd0);
        chk("E_post_rready", {64'd0, S_RREADY}, 65'd0);
        tick();
        src_en = 1'b0;
        chk("E_no_more_writes", 65'(wr_q.size()), 65'd2);

        // F: RRESP error on beat 2
        clear_src(64'hF000_0000_0000_0000, 3, 1);
        src_en = 1'b1;
        start_job(16'd4);
        wait_done("F_done", 40);
        src_en = 1'b0;
        chk("F_err", {64'd0, ERR}, {64'd0, EXP_ERR});
        chk("F_wr_count", 65'(wr_q.size()), 65'd4);
        if (wr_q.size() > 1)
            chk("F_beat2_written", wr_q[1], {1'b0, 64'hF000_0000_0000_0001});
        tick(); tick();
        chk("F_err_sticky", {64'd0, ERR}, {64'd0, EXP_ERR});
        clear_src(64'h1000_0000_0000_0000, 0, -1);
        src_en = 1'b1;
        start_job(16'd1);
        chk("F_err_clear", {64'd0, ERR}, 65'd0);
        wait_done("F2_done", 40);
        src_en = 1'b0;
        chk("F2_beats", 65'(BEATS), 65'd1);

        chk("no_write_when_full", 65'(full_viol), 65'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aq_axi_sdma64_rdpush.md
AQ_AXI_SDMA64_RDPUSH -- requirements
Module: aq_axi_sdma64_rdpush

Interface
REQ-001 SHALL have parameter BEAT_W, default 16, width of job length and beat counter.
REQ-002 SHALL have port CLK  in  1  single clock for all logic.
REQ-003 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port START  in  1  job start pulse, sampled in IDLE only.
REQ-005 SHALL have port LEN  in  BEAT_W  job length in beats, sampled with START.
REQ-006 SHALL have port S_RVALID  in  1  AXI read-data valid.
REQ-007 SHALL have port S_RREADY  out  1  AXI read-data ready, registered.
REQ-008 SHALL have port S_RDATA  in  64  AXI read data.
REQ-009 SHALL have port S_RLAST  in  1  AXI burst last.
REQ-010 SHALL have port S_RRESP  in  2  AXI read response.
REQ-011 SHALL have port FIFO_WREN  out  1  FIFO write enable.
REQ-012 SHALL have port FIFO_DI  out  65  FIFO word: [64]=RLAST, [63:0]=RDATA.
REQ-013 SHALL have port FIFO_FULL  in  1  FIFO full.
REQ-014 SHALL have port FIFO_AFULL  in  1  FIFO almost full.
REQ-015 SHALL have port BUSY  out  1  high in RUN or FLUSH.
REQ-016 SHALL have port DONE  out  1  one-cycle job-complete pulse.
REQ-017 SHALL have port ERR  out  1  sticky response error.
REQ-018 SHALL have port BEATS  out  BEAT_W  beats written to FIFO this job.

Function
REQ-019 SHALL implement states IDLE, RUN, FLUSH; IDLE+START with LEN!=0 -> RUN, loads remaining=LEN, clears BEATS and ERR.
REQ-020 SHALL, on IDLE+START with LEN==0, stay IDLE and pulse DONE the next cycle.
REQ-021 SHALL ignore START outside IDLE.
REQ-022 SHALL hold a 2-entry skid buffer of 65-bit words; a beat is accepted when S_RVALID&&S_RREADY and enters the tail.
REQ-023 SHALL register S_RREADY = (next state RUN) && (next occupancy <=1) && (next remaining !=0) && !FIFO_AFULL, giving one beat/cycle when FIFO not almost full.
REQ-024 SHALL decrement remaining per accepted beat; remaining reaching 0 moves RUN -> FLUSH.
REQ-025 SHALL drive FIFO_WREN = (occupancy!=0) && !FIFO_FULL combinationally, FIFO_DI = head entry; head pops when FIFO_WREN.
REQ-026 SHALL support push and pop in the same cycle with occupancy unchanged and order preserved.
REQ-027 SHALL increment BEATS per FIFO write, wrapping modulo 2^BEAT_W.
REQ-028 SHALL leave FLUSH for IDLE when occupancy reaches 0, pulsing DONE in the cycle IDLE is entered.
REQ-029 SHALL never write the FIFO while FIFO_FULL is high and never drop or duplicate a beat.
REQ-030 SHALL pass S_RLAST unmodified into FIFO_DI[64]; no burst-boundary checking.

Reset
REQ-031 SHALL, on RST high, immediately force IDLE, occupancy 0, remaining 0, S_RREADY 0, FIFO_WREN 0, FIFO_DI 0, BUSY 0, DONE 0, ERR 0, BEATS 0.
REQ-032 SHALL discard skid contents when RST asserts mid-job; no FIFO write after RST.
REQ-033 SHALL resume in IDLE on the first CLK edge after RST deasserts.

Configuration
REQ-034 SHALL, with macro AQ_AXI_SDMA64_RDPUSH_CHK_EN defined, set ERR on any accepted beat with S_RRESP!=2'b00, still writing that beat.
REQ-035 SHALL, without AQ_AXI_SDMA64_RDPUSH_CHK_EN, tie ERR to 0 and ignore S_RRESP.

Verification
REQ-036 SHALL test: START LEN=4, RVALID continuous, FIFO free -> 4 FIFO writes on consecutive cycles, last with DI[64]=RLAST, BEATS=4, one DONE pulse.
REQ-037 SHALL test: LEN=8, FIFO_AFULL high after beat 2 for 5 cycles -> S_RREADY low within 1 cycle, no beat lost, BEATS=8.
REQ-038 SHALL test: FIFO_FULL high with 2 entries held -> FIFO_WREN 0, S_RREADY 0; FULL low -> 2 writes in order.
REQ-039 SHALL test: START LEN=0 -> no RREADY, DONE one cycle later; START during RUN -> ignored.
REQ-040 SHALL test: RST asserted mid-job after 3 of 6 beats -> all outputs 0 same cycle, no further writes.
REQ-041 SHALL test (CHK_EN defined): beat 2 with RRESP=2'b10 -> ERR=1 sticky until next START, beat still written.
